// File: rtl/afe_burst_pulser_if.sv
// Control and status bundle for afe_burst_pulser.
// The master side is the sequencer/bench, and the slave side is the pulser.
interface afe_burst_pulser_if #(
  parameter int unsigned SER_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic             trig;
  logic             abort;
  logic             y0;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] n_pulses;
  logic [SER_W-1:0] word_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] missed_trig;

  modport master (
    output trig, abort, y0, width, period, delay, n_pulses,
    input  word_out, busy, done, burst_cnt, missed_trig
  );

  modport slave (
    input  trig, abort, y0, width, period, delay, n_pulses,
    output word_out, busy, done, burst_cnt, missed_trig
  );
endinterface

// File: rtl/afe_burst_pulser.sv
// Burst pulse-train generator that emits one SER_W-bit serializer word per divclk cycle.
// Pulse timing is tracked with down-counters relative to bit 0 of the current word.
module afe_burst_pulser #(
  parameter int unsigned SER_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 divclk,
  input  logic                 divclk_rst,
  afe_burst_pulser_if.slave    bus
);

  localparam int unsigned PW = CNT_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             trig_q;
  logic [CNT_W-1:0] width_q, width_d;
  logic [PW-1:0]    peff_q, peff_d;
  logic [PW-1:0]    to_start_q, to_start_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] pl_q, pl_d;
  logic [SER_W-1:0] raw_q, raw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] missed_q, missed_d;

  logic             trig_pe;
  logic [PW-1:0]    peff_in;
  logic [SER_W-1:0] word_w;
  logic [PW-1:0]    ts_w;
  logic [CNT_W-1:0] hi_w;
  logic [CNT_W-1:0] pl_w;
  logic             last_w;

  assign trig_pe = bus.trig & ~trig_q;

  // Widen the comparison so that width = all-ones cannot wrap.
  always_comb begin
    peff_in = PW'(bus.width) + PW'(1);
    if ({1'b0, bus.period} > peff_in) peff_in = {1'b0, bus.period};
  end

  // Walk the word window bit by bit. A start sets the high counter and reloads the gap counter.
  always_comb begin
    word_w = '0;
    ts_w   = to_start_q;
    hi_w   = hi_q;
    pl_w   = pl_q;
    for (int i = 0; i < SER_W; i++) begin
      if (ts_w == '0 && pl_w != '0) begin
        hi_w = width_q;
        ts_w = peff_q;
        pl_w = pl_w - CNT_W'(1);
      end
      word_w[i] = (hi_w != '0);
      if (hi_w != '0) hi_w = hi_w - CNT_W'(1);
      if (ts_w != '0) ts_w = ts_w - PW'(1);
    end
    last_w = (pl_w == '0) && (hi_w == '0);
  end

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    peff_d      = peff_q;
    to_start_d  = to_start_q;
    hi_d        = hi_q;
    pl_d        = pl_q;
    raw_d       = raw_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    burst_cnt_d = burst_cnt_q;
    missed_d    = missed_q;

    if (trig_pe && state_q != StIdle && missed_q != '1) missed_d = missed_q + CNT_W'(1);

    unique case (state_q)
      StIdle: begin
        raw_d  = '0;
        busy_d = 1'b0;
        if (trig_pe) begin
          width_d    = bus.width;
          peff_d     = peff_in;
          to_start_d = {1'b0, bus.delay};
          hi_d       = '0;
          pl_d       = bus.n_pulses;
          state_d    = (bus.width == '0 || bus.n_pulses == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (bus.abort) begin
          raw_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          raw_d      = word_w;
          busy_d     = 1'b1;
          to_start_d = ts_w;
          hi_d       = hi_w;
          pl_d       = pl_w;
          if (last_w) state_d = StDone;
        end
      end
      StDone: begin
        raw_d       = '0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge divclk or posedge divclk_rst) begin
    if (divclk_rst) begin
      state_q     <= StIdle;
      trig_q      <= 1'b0;
      width_q     <= '0;
      peff_q      <= '0;
      to_start_q  <= '0;
      hi_q        <= '0;
      pl_q        <= '0;
      raw_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      burst_cnt_q <= '0;
      missed_q    <= '0;
    end else begin
      state_q     <= state_d;
      trig_q      <= bus.trig;
      width_q     <= width_d;
      peff_q      <= peff_d;
      to_start_q  <= to_start_d;
      hi_q        <= hi_d;
      pl_q        <= pl_d;
      raw_q       <= raw_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      burst_cnt_q <= burst_cnt_d;
      missed_q    <= missed_d;
    end
  end

  assign bus.word_out    = raw_q ^ {SER_W{bus.y0}};
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.burst_cnt   = burst_cnt_q;
  assign bus.missed_trig = missed_q;

endmodule

// File: tb/tb_afe_burst_pulser.sv
// Directed bench: a table of single bursts, plus sequences for re-trigger, abort,
// saturation on a narrow instance, and asynchronous reset.
module tb_afe_burst_pulser;

  logic divclk = 1'b0;
  logic divclk_rst = 1'b1;
  always #5 divclk = ~divclk;

  afe_burst_pulser_if #(.SER_W(8), .CNT_W(16)) bus ();
  afe_burst_pulser_if #(.SER_W(4), .CNT_W(4))  b4 ();

  afe_burst_pulser #(.SER_W(8), .CNT_W(16)) dut (
    .divclk     (divclk),
    .divclk_rst (divclk_rst),
    .bus        (bus)
  );

  afe_burst_pulser #(.SER_W(4), .CNT_W(4)) dut4 (
    .divclk     (divclk),
    .divclk_rst (divclk_rst),
    .bus        (b4)
  );

  typedef struct {
    logic [15:0] w;
    logic [15:0] p;
    logic [15:0] d;
    logic [15:0] n;
    logic        y0;
    int          nw;
    logic [31:0] words;  // word k in bits [8k +: 8]
  } vec_t;

  vec_t vecs[8];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge divclk);
    #1;
  endtask

  task automatic fire(input logic [15:0] w, input logic [15:0] p,
                      input logic [15:0] d, input logic [15:0] n);
    bus.width = w; bus.period = p; bus.delay = d; bus.n_pulses = n;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic [7:0] idle;
    v = vecs[idx];
    bus.y0 = v.y0;
    idle = {8{v.y0}};
    fire(v.w, v.p, v.d, v.n);
    for (int k = 0; k < v.nw; k++) begin
      tick();
      chk($sformatf("vec%0d word%0d", idx, k), bus.word_out, v.words[8*k +: 8]);
      chk($sformatf("vec%0d busy%0d", idx, k), bus.busy, 1);
    end
    tick();
    chk($sformatf("vec%0d done", idx), bus.done, 1);
    chk($sformatf("vec%0d busy_at_done", idx), bus.busy, 0);
    chk($sformatf("vec%0d idle_word", idx), bus.word_out, idle);
    exp_cnt++;
    chk($sformatf("vec%0d burst_cnt", idx), bus.burst_cnt, exp_cnt);
    tick();
    chk($sformatf("vec%0d done_clear", idx), bus.done, 0);
  endtask

  initial begin
    vecs[0] = '{w:3,  p:0, d:0, n:1, y0:0, nw:1, words:32'h0000_0007};
    vecs[1] = '{w:20, p:0, d:5, n:1, y0:0, nw:4, words:32'h01FF_FFE0};
    vecs[2] = '{w:2,  p:4, d:0, n:3, y0:0, nw:2, words:32'h0000_0333};
    vecs[3] = '{w:4,  p:2, d:0, n:2, y0:0, nw:2, words:32'h0000_01EF};
    vecs[4] = '{w:3,  p:0, d:0, n:1, y0:1, nw:1, words:32'h0000_00F8};
    vecs[5] = '{w:0,  p:4, d:0, n:1, y0:0, nw:0, words:32'h0};
    vecs[6] = '{w:5,  p:8, d:2, n:0, y0:0, nw:0, words:32'h0};
    vecs[7] = '{w:3,  p:4, d:9, n:2, y0:0, nw:2, words:32'h0000_EE00};

    bus.trig = 0; bus.abort = 0; bus.y0 = 0;
    bus.width = 0; bus.period = 0; bus.delay = 0; bus.n_pulses = 0;
    b4.trig = 0; b4.abort = 0; b4.y0 = 0;
    b4.width = 0; b4.period = 0; b4.delay = 0; b4.n_pulses = 0;

    // Reset state
    #12;
    chk("rst word", bus.word_out, 8'h00);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst burst_cnt", bus.burst_cnt, 0);
    chk("rst missed", bus.missed_trig, 0);
    bus.y0 = 1;
    #1;
    chk("rst word y0", bus.word_out, 8'hFF);
    bus.y0 = 0;
    #8 divclk_rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i);
    bus.y0 = 0;

    // Long burst with two rejected triggers, then abort together with a third trigger.
    fire(16'd8, 16'd16, 16'd0, 16'd10);
    bus.width = 16'd1; bus.n_pulses = 16'd1;  // must not disturb the running burst
    tick();                                   // T+1
    chk("long w0", bus.word_out, 8'hFF);
    bus.trig = 1; tick();                     // T+2
    chk("long w1", bus.word_out, 8'h00);
    bus.trig = 0; tick();                     // T+3
    chk("long w2", bus.word_out, 8'hFF);
    bus.trig = 1; tick();                     // T+4
    chk("long w3", bus.word_out, 8'h00);
    bus.trig = 0; tick();                     // T+5
    chk("long w4", bus.word_out, 8'hFF);
    chk("long missed", bus.missed_trig, 2);
    tick();                                   // T+6
    chk("long w5", bus.word_out, 8'h00);
    chk("long busy", bus.busy, 1);
    bus.abort = 1; bus.trig = 1; tick();      // T+7
    bus.abort = 0; bus.trig = 0;
    chk("abort word", bus.word_out, 8'h00);
    chk("abort busy", bus.busy, 0);
    chk("abort missed", bus.missed_trig, 3);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post_abort done%0d", k), bus.done, 0);
      chk($sformatf("post_abort word%0d", k), bus.word_out, 8'h00);
    end
    chk("abort burst_cnt", bus.burst_cnt, exp_cnt);

    // Narrow instance: missed_trig saturates at 4'hF.
    b4.width = 4'd3; b4.period = 4'd15; b4.delay = 4'd15; b4.n_pulses = 4'd15;
    b4.trig = 1; tick(); b4.trig = 0;
    tick();
    chk("n4 w0", b4.word_out, 4'h0);
    chk("n4 busy", b4.busy, 1);
    for (int r = 1; r <= 20; r++) begin
      b4.trig = 1; tick();
      b4.trig = 0; tick();
      if (r == 10) chk("n4 missed10", b4.missed_trig, 4'd10);
    end
    chk("n4 missed sat", b4.missed_trig, 4'hF);

    // Asynchronous reset in the middle of a burst.
    fire(16'd8, 16'd16, 16'd0, 16'd10);
    tick(); tick(); tick();
    chk("pre_rst busy", bus.busy, 1);
    #2 divclk_rst = 1'b1;
    #1;
    chk("arst word", bus.word_out, 8'h00);
    chk("arst busy", bus.busy, 0);
    chk("arst burst_cnt", bus.burst_cnt, 0);
    chk("arst missed", bus.missed_trig, 0);
    chk("arst n4 missed", b4.missed_trig, 0);
    #10 divclk_rst = 1'b0;
    tick(); tick();
    chk("after_rst word", bus.word_out, 8'h00);
    chk("after_rst busy", bus.busy, 0);
    chk("after_rst done", bus.done, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
